// File: rtl/adder_selftest_ctrl_if.sv
// Operand / result bus between the self-test sequencer and the two adders under test.
// master = sequencer (drives operands), slave = adder pair (returns sums and carries).
interface adder_selftest_ctrl_if #(
   parameter int WIDTH = 4
);
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic [WIDTH-1:0] c_ripple;
   logic             cout_ripple;
   logic [WIDTH-1:0] c_ahead;
   logic             cout_ahead;

   modport master (
      output a, b, cin,
      input  c_ripple, cout_ripple, c_ahead, cout_ahead
   );

   modport slave (
      input  a, b, cin,
      output c_ripple, cout_ripple, c_ahead, cout_ahead
   );
endinterface

// File: rtl/adder_selftest_ctrl.sv
// Exhaustive self-test sequencer for the ripple-carry and lookahead adders.
// Walks every {cin,b,a} vector, compares against a golden sum and stops on the first mismatch.
module adder_selftest_ctrl #(
   parameter int WIDTH    = 4,
   parameter int TICK_DIV = 128,
   parameter int SETTLE   = 1
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic                 start,
   adder_selftest_ctrl_if.master bus,
   output logic                 busy,
   output logic                 done,
   output logic                 pass,
   output logic                 fail,
   output logic [2*WIDTH:0]     fail_vec,
   output logic [1:0]           fail_src
);

   localparam int VW = 2*WIDTH + 1;
   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_APPLY,
      ST_SETTLE,
      ST_CHECK,
      ST_PASS,
      ST_FAIL
   } state_t;

   state_t        state;
   logic [PW-1:0] presc;
   logic          tick;
   logic [SW-1:0] settle_cnt;
   logic [VW-1:0] vec;
   logic          start_pend;
   logic          idle_like;
   logic [WIDTH:0] gold;
   logic          mis_ripple;
   logic          mis_ahead;

   // Free-running prescaler; the FSM only advances on its terminal count.
   assign tick = (int'(presc) == TICK_DIV - 1);

   always_ff @(posedge clk) begin
      if (!resetn)   presc <= '0;
      else if (tick) presc <= '0;
      else           presc <= presc + PW'(1);
   end

   assign bus.a   = vec[WIDTH-1:0];
   assign bus.b   = vec[2*WIDTH-1:WIDTH];
   assign bus.cin = vec[2*WIDTH];

   assign gold = {1'b0, bus.a} + {1'b0, bus.b} + {{WIDTH{1'b0}}, bus.cin};

   // Case inequality so an X/Z on either adder output is treated as a mismatch.
   always_comb begin
      mis_ripple = ({bus.cout_ripple, bus.c_ripple} !== gold);
      mis_ahead  = ({bus.cout_ahead,  bus.c_ahead}  !== gold);
   end

   assign idle_like = (state == ST_IDLE) || (state == ST_PASS) || (state == ST_FAIL);

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state      <= ST_IDLE;
         vec        <= '0;
         settle_cnt <= '0;
         start_pend <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         pass       <= 1'b0;
         fail       <= 1'b0;
         fail_vec   <= '0;
         fail_src   <= '0;
      end else begin
         // Consuming a pending start wins over re-arming, so a held start
         // does not leave a stale request behind once the run begins.
         if (tick && start_pend)     start_pend <= 1'b0;
         else if (start && idle_like) start_pend <= 1'b1;

         if (tick) begin
            case (state)
               ST_IDLE, ST_PASS, ST_FAIL: begin
                  if (start_pend) begin
                     state    <= ST_APPLY;
                     vec      <= '0;
                     busy     <= 1'b1;
                     done     <= 1'b0;
                     pass     <= 1'b0;
                     fail     <= 1'b0;
                     fail_vec <= '0;
                     fail_src <= '0;
                  end
               end
               ST_APPLY: begin
                  settle_cnt <= '0;
                  if (SETTLE == 0) state <= ST_CHECK;
                  else             state <= ST_SETTLE;
               end
               ST_SETTLE: begin
                  if (int'(settle_cnt) >= SETTLE - 1) state <= ST_CHECK;
                  else settle_cnt <= settle_cnt + SW'(1);
               end
               ST_CHECK: begin
                  if (mis_ripple || mis_ahead) begin
                     state    <= ST_FAIL;
                     busy     <= 1'b0;
                     done     <= 1'b1;
                     fail     <= 1'b1;
                     fail_vec <= vec;
                     fail_src <= {mis_ahead, mis_ripple};
                  end else if (&vec) begin
                     state <= ST_PASS;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     pass  <= 1'b1;
                  end else begin
                     state <= ST_APPLY;
                     vec   <= vec + VW'(1);
                  end
               end
               default: begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_adder_selftest_ctrl.sv
// Bench for adder_selftest_ctrl: behavioural adders with injectable faults, a timeline
// model of the run checked every cycle, and directed scenario checks.
module tb_adder_selftest_ctrl;
   localparam int W   = 4;
   localparam int NV  = 512;
   localparam int SET = 1;
   localparam int PER = 2 + SET;

   logic       clk = 1'b0;
   logic       resetn;
   logic       start;
   logic       busy, done, pass, fail;
   logic [8:0] fail_vec;
   logic [1:0] fail_src;

   adder_selftest_ctrl_if #(.WIDTH(W)) bus ();

   adder_selftest_ctrl #(.WIDTH(W), .TICK_DIV(1), .SETTLE(SET)) dut (
      .clk(clk), .resetn(resetn), .start(start), .bus(bus),
      .busy(busy), .done(done), .pass(pass), .fail(fail),
      .fail_vec(fail_vec), .fail_src(fail_src)
   );

   always #5 clk = ~clk;

   int npass = 0;
   int ntotal = 0;
   int cyc = 0;
   int mode = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Adders under test: 0 correct, 1 ripple cout stuck 0, 2 both zero at vec 5, 3 lookahead X.
   logic [4:0] s_tb;
   always_comb begin
      s_tb = {1'b0, bus.a} + {1'b0, bus.b} + {4'b0, bus.cin};
      bus.c_ripple    = s_tb[3:0];
      bus.cout_ripple = s_tb[4];
      bus.c_ahead     = s_tb[3:0];
      bus.cout_ahead  = s_tb[4];
      if (mode == 1) bus.cout_ripple = 1'b0;
      if (mode == 2 && {bus.cin, bus.b, bus.a} == 9'd5) begin
         bus.c_ripple = 4'h0;
         bus.c_ahead  = 4'h0;
      end
      if (mode == 3) bus.c_ahead = 4'b1x1x;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      ntotal++;
      if (act === exp) npass++;
      else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
   endtask

   // Which adders disagree with plain integer addition for vector v under fault mode md.
   function automatic logic [1:0] model_src(input int md, input int v);
      int a, b, c, sum;
      a = v % 16; b = (v / 16) % 16; c = v / 256;
      sum = a + b + c;
      case (md)
         1:       return {1'b0, (sum > 15)};
         2:       return (v == 5 && sum != 0) ? 2'b11 : 2'b00;
         3:       return 2'b10;
         default: return 2'b00;
      endcase
   endfunction

   function automatic int first_fail(input int md);
      for (int v = 0; v < NV; v++) if (model_src(md, v) != 2'b00) return v;
      return -1;
   endfunction

   // Timeline model: vector k is on the bus for PER cycles starting at m_t0 + PER*k.
   bit         m_idle0 = 0;
   bit         m_run   = 0;
   int         m_t0, m_len;
   logic       m_pass;
   logic [8:0] m_fv;
   logic [1:0] m_fs;

   always @(negedge clk) begin
      int d;
      if (m_idle0) begin
         chk("idle_status", {busy, done, pass, fail, fail_vec, fail_src}, 32'h0);
         chk("idle_bus", {bus.cin, bus.b, bus.a}, 32'h0);
      end else if (m_run && cyc >= m_t0) begin
         d = cyc - m_t0;
         if (d < m_len) begin
            chk("run_status", {busy, done, pass, fail, fail_vec, fail_src}, {4'b1000, 11'h0});
            chk("run_vec", {bus.cin, bus.b, bus.a}, d / PER);
         end else begin
            chk("end_status", {busy, done, pass, fail, fail_vec, fail_src},
                {1'b0, 1'b1, m_pass, ~m_pass, m_fv, m_fs});
         end
      end
   end

   task automatic do_reset(input int n);
      @(negedge clk);
      resetn = 1'b0; start = 1'b0;
      m_run = 0; m_idle0 = 0;
      @(negedge clk);
      m_idle0 = 1;
      repeat (n - 1) @(negedge clk);
      resetn = 1'b1;
   endtask

   task automatic start_run(input int md);
      int ff;
      @(negedge clk);
      mode = md;
      ff = first_fail(md);
      m_len  = (ff < 0) ? PER * NV : PER * (ff + 1);
      m_pass = (ff < 0);
      m_fv   = (ff < 0) ? 9'h0 : 9'(ff);
      m_fs   = (ff < 0) ? 2'b00 : model_src(md, ff);
      start  = 1'b1;
      m_t0   = cyc + 2;
      m_idle0 = 0;
      m_run  = 1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(output int len);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!done && n < 5000);
      if (!done) chk("timeout_done", 32'(done), 32'h1);
      len = cyc - (m_t0 - 1);
   endtask

   initial begin
      int len;
      resetn = 1'b0;
      start  = 1'b0;
      do_reset(2);
      chk("reset_status", {busy, done, pass, fail, fail_vec, fail_src}, 32'h0);
      chk("reset_bus", {bus.cin, bus.b, bus.a}, 32'h0);

      chk("model_ff0", first_fail(0), 32'hFFFF_FFFF);
      chk("model_ff1", first_fail(1), 32'h01F);
      chk("model_src1", model_src(1, 'h1F), 32'h1);
      chk("model_ff2", first_fail(2), 32'h005);
      chk("model_ff3", first_fail(3), 32'h000);

      start_run(0);
      wait_done(len);
      chk("pass_len", len, 32'd1537);
      chk("pass_flags", {busy, done, pass, fail}, 4'b0110);

      start_run(1);
      wait_done(len);
      chk("f1_vec", fail_vec, 9'h01F);
      chk("f1_src", fail_src, 2'b01);
      chk("f1_flags", {busy, done, pass, fail}, 4'b0101);

      start_run(2);
      wait_done(len);
      chk("f2_vec", fail_vec, 9'h005);
      chk("f2_src", fail_src, 2'b11);

      start_run(3);
      wait_done(len);
      chk("f3_vec", fail_vec, 9'h000);
      chk("f3_src", fail_src, 2'b10);
      chk("f3_fail", fail, 1'b1);

      start_run(0);
      @(negedge clk);
      chk("restart_clear", {busy, done, pass, fail, fail_vec, fail_src}, {4'b1000, 11'h0});
      wait_done(len);
      chk("restart_pass", {pass, fail}, 2'b10);

      start_run(0);
      repeat (100) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(len);
      chk("busy_start_len", len, 32'd1537);
      repeat (5) @(negedge clk);
      chk("no_queued_start", {busy, pass}, 2'b01);

      start_run(0);
      repeat (50) @(negedge clk);
      chk("midrun_busy", busy, 1'b1);
      do_reset(1);
      @(negedge clk);
      chk("midrun_reset", {busy, done, pass, fail, fail_vec, fail_src}, 32'h0);
      chk("midrun_bus", {bus.cin, bus.b, bus.a}, 32'h0);
      repeat (4) @(negedge clk);

      $display("%0d/%0d checks passed", npass, ntotal);
      $finish;
   end
endmodule
